btn_event_decoder: RTL and testbench

- Sits directly downstream of the switch debouncer and consumes its clean, glitch-free level output.
- Converts that level into discrete user events:
  - single-cycle press and release pulses
  - a long-press pulse
  - a double-click pulse
  - a wrapping press counter
- Feeds the lab's mode-select/display logic, which must act once per user gesture rather than per clock.

---
 rtl/btn_event_pkg.sv | 15 +
 rtl/btn_event_decoder_edge_detect.sv | 28 ++
 rtl/btn_event_decoder.sv | 133 +++++++++++++
 tb/tb_btn_event_decoder.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/btn_event_pkg.sv
// Shared state encoding and default timing parameters for the button event decoder.
package btn_event_pkg;

    typedef enum logic [2:0] {
        IDLE           = 3'd0,
        PRESSED        = 3'd1,
        LONG_HELD      = 3'd2,
        WAIT_GAP       = 3'd3,
        SECOND_PRESSED = 3'd4
    } state_e;

    localparam int DEFAULT_LONG_CNT   = 8;
    localparam int DEFAULT_DCLICK_WIN = 4;

endpackage

// File: rtl/btn_event_decoder_edge_detect.sv
// Registers the debounced button level and flags its rising and falling edges.
module edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic btn_q,
    output logic rise,
    output logic fall
);

    logic btn_d;

    always_comb begin
        btn_d = btn;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_q <= 1'b0;
        end else begin
            btn_q <= btn_d;
        end
    end

    assign rise = btn & ~btn_q;
    assign fall = ~btn & btn_q;

endmodule

// File: rtl/btn_event_decoder.sv
// Turns a clean button level into press/release/long-press/double-click pulses and a press count.
module btn_event_decoder
    import btn_event_pkg::*;
#(
    parameter int LONG_CNT   = DEFAULT_LONG_CNT,
    parameter int DCLICK_WIN = DEFAULT_DCLICK_WIN,
    parameter int CNT_W      = 4,
    parameter int PCNT_W     = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              btn,
    output logic              press_pulse,
    output logic              release_pulse,
    output logic              long_press,
    output logic              double_click,
    output logic              held,
    output logic [PCNT_W-1:0] press_count
);

    logic btn_q;
    logic rise;
    logic fall;

    edge_detect u_edge_detect (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn),
        .btn_q (btn_q),
        .rise  (rise),
        .fall  (fall)
    );

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [CNT_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic [PCNT_W-1:0]  press_count_q, press_count_d;
    logic               press_pulse_q, press_pulse_d;
    logic               release_pulse_q, release_pulse_d;
    logic               long_press_q, long_press_d;
    logic               double_click_q, double_click_d;

    always_comb begin
        state_d         = state_q;
        hold_cnt_d      = hold_cnt_q;
        gap_cnt_d       = gap_cnt_q;
        press_pulse_d   = 1'b0;
        release_pulse_d = 1'b0;
        long_press_d    = 1'b0;
        double_click_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (rise) begin
                    press_pulse_d = 1'b1;
                    hold_cnt_d    = '0;
                    state_d       = PRESSED;
                end
            end
            PRESSED, SECOND_PRESSED: begin
                if (fall) begin
                    release_pulse_d = 1'b1;
                    // Only a first short press opens the double-click window.
                    if (state_q == PRESSED) begin
                        gap_cnt_d = '0;
                        state_d   = WAIT_GAP;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (hold_cnt_q == CNT_W'(LONG_CNT - 1)) begin
                    long_press_d = 1'b1;
                    state_d      = LONG_HELD;
                end else begin
                    hold_cnt_d = hold_cnt_q + CNT_W'(1);
                end
            end
            LONG_HELD: begin
                if (fall) begin
                    release_pulse_d = 1'b1;
                    state_d         = IDLE;
                end
            end
            WAIT_GAP: begin
                if (rise) begin
                    press_pulse_d  = 1'b1;
                    double_click_d = 1'b1;
                    hold_cnt_d     = '0;
                    state_d        = SECOND_PRESSED;
                end else if (gap_cnt_q == CNT_W'(DCLICK_WIN - 1)) begin
                    gap_cnt_d = CNT_W'(DCLICK_WIN);
                    state_d   = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        press_count_d = press_pulse_d ? press_count_q + PCNT_W'(1) : press_count_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            hold_cnt_q      <= '0;
            gap_cnt_q       <= '0;
            press_count_q   <= '0;
            press_pulse_q   <= 1'b0;
            release_pulse_q <= 1'b0;
            long_press_q    <= 1'b0;
            double_click_q  <= 1'b0;
        end else begin
            state_q         <= state_d;
            hold_cnt_q      <= hold_cnt_d;
            gap_cnt_q       <= gap_cnt_d;
            press_count_q   <= press_count_d;
            press_pulse_q   <= press_pulse_d;
            release_pulse_q <= release_pulse_d;
            long_press_q    <= long_press_d;
            double_click_q  <= double_click_d;
        end
    end

    assign press_pulse   = press_pulse_q;
    assign release_pulse = release_pulse_q;
    assign long_press    = long_press_q;
    assign double_click  = double_click_q;
    assign held          = btn_q;
    assign press_count   = press_count_q;

endmodule

// File: tb/tb_btn_event_decoder.sv
// Directed scenarios for btn_event_decoder; obs packs {press, release, long, double, held}.
module tb_btn_event_decoder;
    import btn_event_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn = 1'b0;
    logic       press_pulse, release_pulse, long_press, double_click, held;
    logic [7:0] press_count;
    logic [4:0] obs;

    int          errors = 0;
    int          checks = 0;
    int unsigned exp_count = 0;

    always #5 clk = ~clk;

    btn_event_decoder #(
        .LONG_CNT   (8),
        .DCLICK_WIN (4),
        .CNT_W      (4),
        .PCNT_W     (8)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .btn           (btn),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .long_press    (long_press),
        .double_click  (double_click),
        .held          (held),
        .press_count   (press_count)
    );

    assign obs = {press_pulse, release_pulse, long_press, double_click, held};

    // Drive btn for one sampling edge, then look just after that edge.
    task automatic tick(input logic b);
        btn = b;
        @(posedge clk);
        #1;
    endtask

    task automatic settle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        btn   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (obs !== 5'b0) begin errors++; $display("FAIL reset_outputs: got %b want 00000", obs); end
        checks++; if (press_count !== 8'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", press_count); end
        checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL reset_state: got %0d want IDLE", dut.state_q); end
        @(negedge clk);
        rst_n = 1'b1;
        $display("test_reset done");
    endtask

    task automatic test_short_press;
        logic [4:0] exp;
        for (int i = 0; i < 5; i++) begin
            tick(1'b0);
            checks++; if (obs !== 5'b0) begin errors++; $display("FAIL short_idle %0d: got %b want 00000", i, obs); end
        end
        for (int i = 0; i < 3; i++) begin
            tick(1'b1);
            exp = {(i == 0), 3'b000, 1'b1};
            if (i == 0) exp_count++;
            checks++; if (obs !== exp) begin errors++; $display("FAIL short_high %0d: got %b want %b", i, obs, exp); end
        end
        tick(1'b0);
        checks++; if (obs !== 5'b01000) begin errors++; $display("FAIL short_release: got %b want 01000", obs); end
        checks++; if (press_count !== 8'd1) begin errors++; $display("FAIL short_count: got %0d want 1", press_count); end
        for (int i = 0; i < 4; i++) begin
            tick(1'b0);
            checks++; if (obs !== 5'b0) begin errors++; $display("FAIL short_gap %0d: got %b want 00000", i, obs); end
            if (i == 2) begin
                checks++; if (dut.state_q !== WAIT_GAP) begin errors++; $display("FAIL short_state_gap: got %0d want WAIT_GAP", dut.state_q); end
            end
        end
        checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL short_state_idle: got %0d want IDLE", dut.state_q); end
        $display("test_short_press done");
    endtask

    task automatic test_long_press;
        logic [4:0] exp;
        for (int i = 0; i < 12; i++) begin
            tick(1'b1);
            exp = {(i == 0), 1'b0, (i == 8), 1'b0, 1'b1};
            if (i == 0) exp_count++;
            checks++; if (obs !== exp) begin errors++; $display("FAIL long_hold %0d: got %b want %b", i, obs, exp); end
        end
        tick(1'b0);
        checks++; if (obs !== 5'b01000) begin errors++; $display("FAIL long_release: got %b want 01000", obs); end
        tick(1'b0);
        tick(1'b1);
        exp_count++;
        checks++; if (obs !== 5'b10001) begin errors++; $display("FAIL long_repress: got %b want 10001", obs); end
        tick(1'b0);
        checks++; if (obs !== 5'b01000) begin errors++; $display("FAIL long_rerelease: got %b want 01000", obs); end
        settle(5);
        checks++; if (press_count !== 8'(exp_count)) begin errors++; $display("FAIL long_count: got %0d want %0d", press_count, 8'(exp_count)); end
        $display("test_long_press done");
    endtask

    task automatic test_double_click;
        logic       pat  [10];
        logic [3:0] expv [10];
        pat  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        expv = '{4'b1000, 4'b0000, 4'b0100, 4'b0000, 4'b1001,
                 4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b0100};
        for (int i = 0; i < 10; i++) begin
            tick(pat[i]);
            if (expv[i][3]) exp_count++;
            checks++; if (obs !== {expv[i], pat[i]}) begin errors++; $display("FAIL dclick %0d: got %b want %b", i, obs, {expv[i], pat[i]}); end
        end
        settle(5);
        checks++; if (press_count !== 8'(exp_count)) begin errors++; $display("FAIL dclick_count: got %0d want %0d", press_count, 8'(exp_count)); end
        $display("test_double_click done");
    endtask

    task automatic test_window_edge;
        logic       pat  [15];
        logic [3:0] expv [15];
        pat  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
                 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        expv = '{4'b1000, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b1001, 4'b0100,
                 4'b1000, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b0100};
        for (int i = 0; i < 15; i++) begin
            tick(pat[i]);
            if (expv[i][3]) exp_count++;
            checks++; if (obs !== {expv[i], pat[i]}) begin errors++; $display("FAIL window %0d: got %b want %b", i, obs, {expv[i], pat[i]}); end
        end
        settle(5);
        $display("test_window_edge done");
    endtask

    task automatic test_toggle;
        logic       b;
        logic [3:0] e;
        for (int i = 0; i < 8; i++) begin
            b = (i % 2 == 0);
            case (i % 4)
                0:       e = 4'b1000;
                2:       e = 4'b1001;
                default: e = 4'b0100;
            endcase
            tick(b);
            if (e[3]) exp_count++;
            checks++; if (obs !== {e, b}) begin errors++; $display("FAIL toggle %0d: got %b want %b", i, obs, {e, b}); end
        end
        settle(5);
        checks++; if (press_count !== 8'(exp_count)) begin errors++; $display("FAIL toggle_count: got %0d want %0d", press_count, 8'(exp_count)); end
        $display("test_toggle done");
    endtask

    task automatic test_wrap;
        logic [7:0] start;
        start = 8'(exp_count);
        for (int n = 0; n < 256; n++) begin
            tick(1'b1);
            exp_count++;
            checks++; if ({obs, press_count} !== {5'b10001, 8'(exp_count)}) begin
                errors++; $display("FAIL wrap_press %0d: got %b/%0d want 10001/%0d", n, obs, press_count, 8'(exp_count));
            end
            for (int j = 0; j < 9; j++) begin
                tick(1'b0);
                checks++; if (obs !== ((j == 0) ? 5'b01000 : 5'b00000)) begin
                    errors++; $display("FAIL wrap_gap %0d.%0d: got %b", n, j, obs);
                end
            end
        end
        checks++; if (press_count !== start) begin errors++; $display("FAIL wrap_final: got %0d want %0d", press_count, start); end
        $display("test_wrap done");
    endtask

    task automatic test_reset_mid_hold;
        logic [4:0] exp;
        for (int i = 0; i < 6; i++) begin
            tick(1'b1);
            exp = {(i == 0), 3'b000, 1'b1};
            checks++; if (obs !== exp) begin errors++; $display("FAIL rhold_pre %0d: got %b want %b", i, obs, exp); end
        end
        #2;
        rst_n = 1'b0;
        #1;
        exp_count = 0;
        checks++; if ({obs, press_count} !== 13'b0) begin errors++; $display("FAIL rhold_reset: got %b/%0d want 00000/0", obs, press_count); end
        checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL rhold_state: got %0d want IDLE", dut.state_q); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick(1'b1);
            exp = {(i == 0), 1'b0, (i == 8), 1'b0, 1'b1};
            if (i == 0) exp_count++;
            checks++; if (obs !== exp) begin errors++; $display("FAIL rhold_post %0d: got %b want %b", i, obs, exp); end
        end
        tick(1'b0);
        checks++; if (obs !== 5'b01000) begin errors++; $display("FAIL rhold_release: got %b want 01000", obs); end
        settle(5);
        checks++; if (press_count !== 8'd1) begin errors++; $display("FAIL rhold_count: got %0d want 1", press_count); end
        $display("test_reset_mid_hold done");
    endtask

    task automatic test_reset_mid_gap;
        tick(1'b1);
        exp_count++;
        checks++; if (obs !== 5'b10001) begin errors++; $display("FAIL rgap_press: got %b want 10001", obs); end
        tick(1'b0);
        checks++; if (obs !== 5'b01000) begin errors++; $display("FAIL rgap_release: got %b want 01000", obs); end
        tick(1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        exp_count = 0;
        checks++; if ({obs, press_count} !== 13'b0) begin errors++; $display("FAIL rgap_reset: got %b/%0d want 00000/0", obs, press_count); end
        @(negedge clk);
        rst_n = 1'b1;
        tick(1'b1);
        exp_count++;
        checks++; if (obs !== 5'b10001) begin errors++; $display("FAIL rgap_repress: got %b want 10001", obs); end
        tick(1'b0);
        checks++; if (obs !== 5'b01000) begin errors++; $display("FAIL rgap_rerelease: got %b want 01000", obs); end
        settle(5);
        checks++; if (press_count !== 8'(exp_count)) begin errors++; $display("FAIL rgap_count: got %0d want %0d", press_count, 8'(exp_count)); end
        $display("test_reset_mid_gap done");
    endtask

    initial begin
        test_reset;
        test_short_press;
        test_long_press;
        test_double_click;
        test_window_edge;
        test_toggle;
        test_wrap;
        test_reset_mid_hold;
        test_reset_mid_gap;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
